branch_history_table: RTL and testbench
=======================================

Name: branch_history_table

Overview:
- Per-PC branch predictor for the IF stage, answering prediction lookups from the IF PC.
- Receives resolved branch outcomes from the ID stage, where branch compare and NPC are resolved.
- Replaces the single global 2-bit predict state with an indexed, tagged table of 2-bit saturating counters plus stored taken-targets.
- Keeps mispredict/update statistics for the testbench and debug.

Parameters:
IDX_W, 6, index width; table depth = 2**IDX_W entries, index = pc[IDX_W+1:2]
TAG_W, 8, tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
lk_pc  in  32  IF-stage PC to predict
lk_taken  out  1  predicted taken (combinational from lk_pc and table state)
lk_target  out  32  predicted next PC
upd_valid  in  1  one-cycle pulse: a branch resolved in ID this cycle (ID asserts it only on the cycle the branch leaves ID, never during stall cycles)
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken-target (branch-occur PC)
upd_pred  in  1  prediction that was used for this branch when fetched
mispredict  out  1  registered; high the cycle after an update whose upd_pred != upd_taken
upd_cnt  out  CNT_W  number of accepted updates
miss_cnt  out  CNT_W  number of mispredicted updates

Behaviour:
- Storage per entry: valid(1), tag(TAG_W), ctr(2), target(32).
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Reset (rst=1 at a clock edge): all valid=0, all ctr=00, mispredict=0, upd_cnt=0, miss_cnt=0. Reset asserted mid-operation overrides any concurrent upd_valid. Tag/target contents are don't-care after reset.
- Lookup (combinational, zero latency): hit = valid[i] && tag[i]==tag(lk_pc).
  - lk_taken = hit && ctr[i][1].
  - lk_target = target[i] if lk_taken, else lk_pc+4 (32-bit wrap).
- Update, on a clock edge with upd_valid=1, entry j = index(upd_pc), uhit = valid[j] && tag[j]==tag(upd_pc):
  - uhit && upd_taken: ctr = sat_inc(ctr) (11 stays 11); target = upd_target.
  - uhit && !upd_taken: ctr = sat_dec(ctr) (00 stays 00); target unchanged.
  - !uhit && upd_taken: allocate/replace: valid=1, tag=tag(upd_pc), ctr=01, target=upd_target.
  - !uhit && !upd_taken: no table change (no allocation for not-taken).
- Statistics, when upd_valid=1:
  - upd_cnt increments.
  - miss_cnt increments when upd_pred != upd_taken.
  - mispredict <= (upd_pred != upd_taken).
  - When upd_valid=0: mispredict <= 0.
  - Both counters wrap modulo 2**CNT_W.
- Same-cycle lookup and update to the same entry: the lookup sees the pre-update state (no bypass). The new state is visible from the next cycle.
- upd_valid held high for N cycles is counted as N updates. The ID stage must not do this during stalls.
- No X on outputs after reset, including for lookup of never-written entries (hit=0).

Test Plan:
1. Reset; lookup lk_pc=0x00003000 -> lk_taken=0, lk_target=0x00003004; upd_cnt=0, miss_cnt=0.
2. Update pc=0x00003000 taken target=0x00003040 pred=0 -> next cycle mispredict=1, miss_cnt=1, lookup gives lk_taken=0 (ctr=01). A second identical update -> ctr=10, lk_taken=1, lk_target=0x00003040.
3. From ctr=11, apply two not-taken updates -> ctr 10 then 01: lk_taken=1 after the first, 0 after the second. Repeated taken updates at 11 stay at 11; repeated not-taken updates at 00 stay at 00.
4. Alias test: train pc=0x00003000 to 11, then a taken update for pc=0x00003100 (same index, different tag) -> entry replaced with ctr=01. Lookup 0x00003000 -> miss, lk_target=0x00003004.
5. Not-taken update to an empty entry pc=0x00004008 -> no allocation, lookup still misses. Same-cycle lookup and update of one entry -> lookup returns the old value.
6. Assert rst while upd_valid=1 after training -> all entries miss, counters=0, mispredict=0. Drive 2**CNT_W updates -> upd_cnt wraps to 0.

Source files
------------

// File: rtl/branch_history_table_if.sv
// branch_history_table_if: IF lookup, ID update and statistics bundle for the branch history table
interface branch_history_table_if #(parameter int CNT_W = 16);
  logic [31:0] lk_pc;
  logic lk_taken;
  logic [31:0] lk_target;
  logic upd_valid;
  logic [31:0] upd_pc;
  logic upd_taken;
  logic [31:0] upd_target;
  logic upd_pred;
  logic mispredict;
  logic [CNT_W-1:0] upd_cnt;
  logic [CNT_W-1:0] miss_cnt;
  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred,
    input lk_taken, lk_target, mispredict, upd_cnt, miss_cnt
  );
  modport slave (
    input lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred,
    output lk_taken, lk_target, mispredict, upd_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_history_table.sv
// branch_history_table: tagged table of 2-bit saturating counters with stored taken-targets
module branch_history_table #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  branch_history_table_if.slave b
);
  localparam int DEPTH = 1 << IDX_W;
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag [DEPTH];
  logic [1:0] ctr [DEPTH];
  logic [31:0] tgt [DEPTH];
  logic [IDX_W-1:0] li, ui;
  logic [TAG_W-1:0] lt, ut;
  logic hit, uhit, miss;
  assign li = b.lk_pc[IDX_W+1:2];
  assign lt = b.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ui = b.upd_pc[IDX_W+1:2];
  assign ut = b.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign hit = valid[li] && tag[li] == lt;
  assign uhit = valid[ui] && tag[ui] == ut;
  assign miss = b.upd_pred != b.upd_taken;
  assign b.lk_taken = hit && ctr[li][1];
  assign b.lk_target = b.lk_taken ? tgt[li] : b.lk_pc + 32'd4;
  logic unused_pc_bits;
  assign unused_pc_bits = ^{b.lk_pc[31:IDX_W+TAG_W+2], b.lk_pc[1:0],
                            b.upd_pc[31:IDX_W+TAG_W+2], b.upd_pc[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b00;
      b.mispredict <= 1'b0;
      b.upd_cnt <= '0;
      b.miss_cnt <= '0;
    end else begin
      b.mispredict <= b.upd_valid && miss;
      if (b.upd_valid) begin
        b.upd_cnt <= b.upd_cnt + 1'b1;
        b.miss_cnt <= b.miss_cnt + CNT_W'(miss);
        if (uhit)
          ctr[ui] <= b.upd_taken ? (ctr[ui] == 2'b11 ? 2'b11 : ctr[ui] + 2'd1)
                                 : (ctr[ui] == 2'b00 ? 2'b00 : ctr[ui] - 2'd1);
        else if (b.upd_taken) begin
          valid[ui] <= 1'b1;
          ctr[ui] <= 2'b01;
        end
      end
    end
  end
  // Tag is rewritten on every taken update; on a hit it is unchanged anyway.
  always_ff @(posedge clk) begin
    if (!rst && b.upd_valid && b.upd_taken) begin
      tag[ui] <= ut;
      tgt[ui] <= b.upd_target;
    end
  end
endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table: directed plus random checks against a table-level reference model
module tb_branch_history_table;
  localparam int CNT_W = 10;
  localparam int MOD = 1 << CNT_W;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  branch_history_table_if #(.CNT_W(CNT_W)) bus ();
  branch_history_table #(.IDX_W(6), .TAG_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .b(bus.slave)
  );
  always #5 clk = ~clk;

  bit m_valid [DEPTH];
  int m_tag [DEPTH];
  int m_ctr [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int m_upd, m_miss;
  bit m_mp;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction
  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    int j, t;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 0;
        m_ctr[i] = 0;
      end
      m_upd = 0;
      m_miss = 0;
      m_mp = 0;
    end else begin
      m_mp = bus.upd_valid && (bus.upd_pred != bus.upd_taken);
      if (bus.upd_valid) begin
        m_upd = (m_upd + 1) % MOD;
        if (bus.upd_pred != bus.upd_taken) m_miss = (m_miss + 1) % MOD;
        j = idx_of(bus.upd_pc);
        t = tag_of(bus.upd_pc);
        if (m_valid[j] && m_tag[j] == t) begin
          if (bus.upd_taken) begin
            m_ctr[j] = m_ctr[j] < 3 ? m_ctr[j] + 1 : 3;
            m_tgt[j] = bus.upd_target;
          end else m_ctr[j] = m_ctr[j] > 0 ? m_ctr[j] - 1 : 0;
        end else if (bus.upd_taken) begin
          m_valid[j] = 1;
          m_tag[j] = t;
          m_ctr[j] = 1;
          m_tgt[j] = bus.upd_target;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus.upd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic set_upd(logic [31:0] pc, logic taken, logic [31:0] target, logic pred);
    bus.upd_valid = 1'b1;
    bus.upd_pc = pc;
    bus.upd_taken = taken;
    bus.upd_target = target;
    bus.upd_pred = pred;
  endtask

  task automatic upd(logic [31:0] pc, logic taken, logic [31:0] target, logic pred);
    set_upd(pc, taken, target, pred);
    tick();
  endtask

  task automatic check_lookup(logic [31:0] pc);
    int i;
    bit exp_taken;
    bus.lk_pc = pc;
    #1;
    i = idx_of(pc);
    exp_taken = m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
    chk("lk_taken", 32'(bus.lk_taken), 32'(exp_taken));
    chk("lk_target", bus.lk_target, exp_taken ? m_tgt[i] : pc + 32'd4);
  endtask

  task automatic check_stats();
    chk("mispredict", 32'(bus.mispredict), 32'(m_mp));
    chk("upd_cnt", 32'(bus.upd_cnt), 32'(m_upd));
    chk("miss_cnt", 32'(bus.miss_cnt), 32'(m_miss));
  endtask

  initial begin
    logic [31:0] pc;
    bus.lk_pc = 32'h0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = 32'h0;
    bus.upd_taken = 1'b0;
    bus.upd_target = 32'h0;
    bus.upd_pred = 1'b0;
    tick();
    check_stats();
    check_lookup(32'h0000_3000);
    chk("reset_target", bus.lk_target, 32'h0000_3004);
    upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b0);
    check_stats();
    chk("first_mispredict", 32'(bus.mispredict), 32'd1);
    check_lookup(32'h0000_3000);
    chk("weak_nt", 32'(bus.lk_taken), 32'd0);
    upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b0);
    check_lookup(32'h0000_3000);
    chk("weak_t_target", bus.lk_target, 32'h0000_3040);
    for (int k = 0; k < 3; k++) begin
      upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b1);
      check_stats();
      check_lookup(32'h0000_3000);
    end
    upd(32'h0000_3000, 1'b0, 32'h0, 1'b1);
    check_lookup(32'h0000_3000);
    chk("dec_to_10", 32'(bus.lk_taken), 32'd1);
    upd(32'h0000_3000, 1'b0, 32'h0, 1'b1);
    check_lookup(32'h0000_3000);
    chk("dec_to_01", 32'(bus.lk_taken), 32'd0);
    for (int k = 0; k < 3; k++) upd(32'h0000_3000, 1'b0, 32'h0, 1'b0);
    upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b0);
    check_lookup(32'h0000_3000);
    chk("floor_00", 32'(bus.lk_taken), 32'd0);
    check_stats();
    for (int k = 0; k < 3; k++) upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b1);
    upd(32'h0000_3100, 1'b1, 32'h0000_3180, 1'b0);
    check_lookup(32'h0000_3000);
    chk("alias_miss", bus.lk_target, 32'h0000_3004);
    check_lookup(32'h0000_3100);
    upd(32'h0000_4008, 1'b0, 32'h0000_4444, 1'b1);
    check_lookup(32'h0000_4008);
    chk("no_alloc", bus.lk_target, 32'h0000_400c);
    set_upd(32'h0000_3100, 1'b1, 32'h0000_3180, 1'b0);
    check_lookup(32'h0000_3100);
    chk("same_cycle_old", 32'(bus.lk_taken), 32'd0);
    tick();
    check_lookup(32'h0000_3100);
    chk("same_cycle_new", bus.lk_target, 32'h0000_3180);
    check_stats();
    for (int k = 0; k < 600; k++) begin
      pc = 32'h0000_3000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) < 7)
        set_upd(pc, 1'($urandom), 32'h0001_0000 | (32'($urandom_range(0, 255)) << 2), 1'($urandom));
      pc = 32'h0000_3000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      check_lookup(pc);
      tick();
      check_stats();
    end
    for (int k = 0; k < 3; k++) upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b0);
    set_upd(32'h0000_3000, 1'b1, 32'h0000_3040, 1'b0);
    rst = 1'b1;
    tick();
    check_stats();
    chk("rst_upd_cnt", 32'(bus.upd_cnt), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    check_lookup(32'h0000_3000);
    chk("rst_miss", 32'(bus.lk_taken), 32'd0);
    check_lookup(32'h0000_3100);
    for (int k = 0; k < MOD; k++) begin
      set_upd(32'h0000_5000, 1'b0, 32'h0, 1'b0);
      tick();
      if (k == MOD - 2) chk("pre_wrap", 32'(bus.upd_cnt), 32'(MOD - 1));
    end
    check_stats();
    chk("wrap_upd_cnt", 32'(bus.upd_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
